// File: rtl/multichannel_gain_divider.sv
// multichannel_gain_divider
//   Buffers one reference/error amplitude pair per channel and shares a
//   single restoring divider across the channels in round-robin order.
//   Each result is the Q.F ratio reference/error. It is tagged with its
//   channel index and saturates on overflow or on a zero error.
//
//   Handshake: i_valid[c] is a fire-and-forget strobe; there is no ready.
//   A pair is captured on every edge where i_valid[c] is high. If an older
//   pair for that channel is still waiting, the new pair replaces it and
//   o_overrun[c] latches. o_valid is a one-cycle strobe, and the result
//   outputs hold their value until the next o_valid.
//
//   Optional feature macro: GAIN_DIVIDER_ROUND_EN
//     defined   - one extra quotient bit is produced, and the result is
//                 rounded half-up (one extra cycle of latency).
//     undefined - the result is truncated (floor).
module multichannel_gain_divider #(
  parameter int NUM_CHANNELS        = 2,
  parameter int CHANNEL_ID_SIZE     = 1,
  parameter int AMPLITUDE_DATA_SIZE = 16,
  parameter int QUOTIENT_SIZE       = 8,
  parameter int FRACTIONAL_SIZE     = 8
) (
  input  logic                                        i_clock,
  input  logic                                        i_reset,
  input  logic [NUM_CHANNELS-1:0]                     i_valid,
  input  logic [NUM_CHANNELS*AMPLITUDE_DATA_SIZE-1:0] i_reference,
  input  logic [NUM_CHANNELS*AMPLITUDE_DATA_SIZE-1:0] i_error,
  output logic                                        o_valid,
  output logic [CHANNEL_ID_SIZE-1:0]                  o_channel,
  output logic [QUOTIENT_SIZE-1:0]                    o_quotient,
  output logic [FRACTIONAL_SIZE-1:0]                  o_fractional,
  output logic                                        o_saturated,
  output logic                                        o_busy,
  output logic [NUM_CHANNELS-1:0]                     o_overrun
);

  localparam int A = AMPLITUDE_DATA_SIZE;
  localparam int W = QUOTIENT_SIZE + FRACTIONAL_SIZE;
  localparam int N = A + FRACTIONAL_SIZE;
`ifdef GAIN_DIVIDER_ROUND_EN
  localparam int NQ = N + 1;   // the extra bit is the rounding bit
`else
  localparam int NQ = N;
`endif
  localparam int CNT_W = $clog2(NQ + 1);
  // This is wide enough to hold any quotient next to the saturation limit.
  localparam int CW = NQ + W + 1;

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  state_t                     state;
  state_t                     state_next;

  logic [A-1:0]               ref_slot [NUM_CHANNELS];
  logic [A-1:0]               err_slot [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]    pending;

  logic [CHANNEL_ID_SIZE-1:0] rr_ptr;
  logic [CHANNEL_ID_SIZE-1:0] sel;
  logic                       sel_found;
  logic [A-1:0]               sel_ref;
  logic [A-1:0]               sel_err;
  logic [NUM_CHANNELS-1:0]    grant;
  int                         arb_idx;

  logic [NQ-1:0]              dividend;
  logic [A-1:0]               divisor;
  logic [A-1:0]               rem;
  logic [NQ-1:0]              quo;
  logic [CNT_W-1:0]           cnt;

  logic [A:0]                 rem_shift;
  logic [A-1:0]               rem_diff;
  logic                       rem_ge;

  logic [NQ-1:0]              rounded;
  logic [CW-1:0]              ext;
  logic [CW-1:0]              limit;
  logic                       sat;

  assign o_busy = (state != IDLE);

  // Round-robin arbiter: find the first pending channel after the last one served.
  always_comb begin
    sel_found = 1'b0;
    sel       = '0;
    sel_ref   = '0;
    sel_err   = '0;
    grant     = '0;
    arb_idx   = 0;
    for (int i = 1; i <= NUM_CHANNELS; i++) begin
      arb_idx = int'(rr_ptr) + i;
      if (arb_idx >= NUM_CHANNELS) arb_idx = arb_idx - NUM_CHANNELS;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (!sel_found && (c == arb_idx) && pending[c]) begin
          sel_found = 1'b1;
          sel       = CHANNEL_ID_SIZE'(c);
          sel_ref   = ref_slot[c];
          sel_err   = err_slot[c];
          grant[c]  = (state == IDLE);
        end
      end
    end
  end

  // Pending slots: a new capture beats a consume at the same edge, and only an unconsumed overwrite counts as an overrun.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pending   <= '0;
      o_overrun <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        ref_slot[c] <= '0;
        err_slot[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (i_valid[c]) begin
          ref_slot[c] <= i_reference[c*A +: A];
          err_slot[c] <= i_error[c*A +: A];
          pending[c]  <= 1'b1;
          if (pending[c] && !grant[c]) o_overrun[c] <= 1'b1;
        end else if (grant[c]) begin
          pending[c] <= 1'b0;
        end
      end
    end
  end

  // Register the FSM state.
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  // Next state: load in IDLE, then NQ divide steps, then one result cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sel_found) state_next = DIVIDE;
      DIVIDE:  if (cnt == CNT_W'(NQ - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One restoring step: shift in the next dividend bit, then subtract the divisor if it fits.
  always_comb begin
    rem_shift = {rem, dividend[NQ-1]};
    rem_ge    = (rem_shift >= {1'b0, divisor});
    rem_diff  = rem_shift[A-1:0] - divisor;
  end

  // Apply optional rounding, then saturate anything above the W-bit limit or any divide by zero.
  always_comb begin
`ifdef GAIN_DIVIDER_ROUND_EN
    rounded = {1'b0, quo[NQ-1:1]} + NQ'(quo[0]);
`else
    rounded = quo;
`endif
    ext            = '0;
    ext[NQ-1:0]    = rounded;
    limit          = '0;
    limit[W-1:0]   = '1;
    sat            = (divisor == '0) || (ext > limit);
  end

  // Divider datapath and result registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rr_ptr       <= CHANNEL_ID_SIZE'(NUM_CHANNELS - 1);
      dividend     <= '0;
      divisor      <= '0;
      rem          <= '0;
      quo          <= '0;
      cnt          <= '0;
      o_valid      <= 1'b0;
      o_channel    <= '0;
      o_quotient   <= '0;
      o_fractional <= '0;
      o_saturated  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_found) begin
            dividend <= NQ'(sel_ref) << (NQ - A);
            divisor  <= sel_err;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            rr_ptr   <= sel;
          end
        end
        DIVIDE: begin
          rem      <= rem_ge ? rem_diff : rem_shift[A-1:0];
          quo      <= {quo[NQ-2:0], rem_ge};
          dividend <= dividend << 1;
          cnt      <= cnt + 1'b1;
        end
        DONE: begin
          o_valid     <= 1'b1;
          o_channel   <= rr_ptr;
          o_saturated <= sat;
          if (sat) {o_quotient, o_fractional} <= '1;
          else     {o_quotient, o_fractional} <= ext[W-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multichannel_gain_divider.sv
// Testbench for multichannel_gain_divider (default parameters).
// Expected results come from plain integer arithmetic on the operands.
// Service order comes from the round-robin rule: the search starts after the last channel served.
module tb_multichannel_gain_divider;

  localparam int NCH = 2;
  localparam int CIW = 1;
  localparam int A   = 16;
  localparam int QS  = 8;
  localparam int FS  = 8;
  localparam int W   = QS + FS;
  localparam int N   = A + FS;
`ifdef GAIN_DIVIDER_ROUND_EN
  localparam int LAT = N + 3;
`else
  localparam int LAT = N + 2;
`endif
  localparam int EW  = CIW + 1 + W;   // {channel, saturated, quotient, fractional}

  // ---------------- clock / reset ----------------
  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NCH-1:0]       i_valid;
  logic [NCH*A-1:0]     i_reference;
  logic [NCH*A-1:0]     i_error;
  logic                 o_valid;
  logic [CIW-1:0]       o_channel;
  logic [QS-1:0]        o_quotient;
  logic [FS-1:0]        o_fractional;
  logic                 o_saturated;
  logic                 o_busy;
  logic [NCH-1:0]       o_overrun;

  always #5 clk = ~clk;

  multichannel_gain_divider #(
    .NUM_CHANNELS(NCH), .CHANNEL_ID_SIZE(CIW), .AMPLITUDE_DATA_SIZE(A),
    .QUOTIENT_SIZE(QS), .FRACTIONAL_SIZE(FS)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_valid(i_valid),
    .i_reference(i_reference), .i_error(i_error),
    .o_valid(o_valid), .o_channel(o_channel), .o_quotient(o_quotient),
    .o_fractional(o_fractional), .o_saturated(o_saturated),
    .o_busy(o_busy), .o_overrun(o_overrun)
  );

  int n_compared   = 0;
  int n_mismatched = 0;
  int edge_cnt     = 0;
  int valid_count  = 0;
  int last_served  = NCH - 1;
  logic [EW-1:0] exp_q[$];
  int valid_edges[$];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: ratio from integer arithmetic, rounded half-up when enabled.
  function automatic logic [EW-1:0] model(input int ch, input logic [A-1:0] r, input logic [A-1:0] e);
    longint unsigned num;
    longint unsigned q;
    logic            sat;
    logic [W-1:0]    res;
    num = longint'(r) << FS;
    q   = 0;
    if (e != 0) begin
`ifdef GAIN_DIVIDER_ROUND_EN
      q = ((2 * num / e) + 1) / 2;
`else
      q = num / e;
`endif
    end
    sat = (e == 0) || (q > ((64'd1 << W) - 1));
    res = sat ? {W{1'b1}} : W'(q);
    return {CIW'(ch), sat, res};
  endfunction

  function automatic logic [EW-1:0] exp_word(input int ch, input logic sat, input logic [W-1:0] v);
    return {CIW'(ch), sat, v};
  endfunction

  function automatic int lat_of(input int idx, input int k);
    return (valid_edges.size() > idx) ? valid_edges[idx] - k : -1;
  endfunction

  // Scoreboard: every o_valid pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && o_valid === 1'b1) begin
      valid_count++;
      valid_edges.push_back(edge_cnt);
      if (exp_q.size() == 0) check("spurious_valid", o_valid, 1'b0);
      else check("result", {o_channel, o_saturated, o_quotient, o_fractional}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic put(input logic [NCH-1:0] m, input logic [A-1:0] r0, input logic [A-1:0] e0,
                     input logic [A-1:0] r1, input logic [A-1:0] e1, output int k);
    @(negedge clk);
    i_valid     = m;
    i_reference = {r1, r0};
    i_error     = {e1, e0};
    k           = edge_cnt + 1;
  endtask

  task automatic release_inputs();
    @(negedge clk);
    i_valid = '0;
  endtask

  task automatic send(input logic [NCH-1:0] m, input logic [A-1:0] r0, input logic [A-1:0] e0,
                      input logic [A-1:0] r1, input logic [A-1:0] e1, output int k);
    put(m, r0, e0, r1, e1, k);
    release_inputs();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_valid"},    o_valid,      0);
    check({pfx, "_channel"},  o_channel,    0);
    check({pfx, "_quotient"}, o_quotient,   0);
    check({pfx, "_frac"},     o_fractional, 0);
    check({pfx, "_sat"},      o_saturated,  0);
    check({pfx, "_busy"},     o_busy,       0);
    check({pfx, "_overrun"},  o_overrun,    0);
  endtask

  // Bound the whole run in case the design hangs.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", n_compared);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int k2;
    int vc;
    i_valid     = '0;
    i_reference = '0;
    i_error     = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Exact ratio: 300/100 = 3.0.
    valid_edges.delete();
    exp_q.push_back(exp_word(0, 1'b0, 16'h0300));
    send(2'b01, 16'd300, 16'd100, 16'd0, 16'd0, k);
    repeat (3) @(negedge clk);
    check("busy_mid_divide", o_busy, 1);
    drain(4 * LAT);
    check("lat_300_100", lat_of(0, k), LAT);
    last_served = 0;

    // Fractional result: 2/3 -> 0xAA truncated, or 0xAB rounded.
    valid_edges.delete();
`ifdef GAIN_DIVIDER_ROUND_EN
    exp_q.push_back(exp_word(0, 1'b0, 16'h00AB));
`else
    exp_q.push_back(exp_word(0, 1'b0, 16'h00AA));
`endif
    send(2'b01, 16'd2, 16'd3, 16'd0, 16'd0, k);
    drain(4 * LAT);
    check("lat_2_3", lat_of(0, k), LAT);

    // Overflow saturation, then divide-by-zero saturation, both on channel 1.
    valid_edges.delete();
    exp_q.push_back(exp_word(1, 1'b1, 16'hFFFF));
    send(2'b10, 16'd0, 16'd0, 16'd1000, 16'd1, k);
    drain(4 * LAT);
    check("lat_overflow", lat_of(0, k), LAT);
    valid_edges.delete();
    exp_q.push_back(exp_word(1, 1'b1, 16'hFFFF));
    send(2'b10, 16'd0, 16'd0, 16'd5, 16'd0, k);
    drain(4 * LAT);
    check("lat_div_zero", lat_of(0, k), LAT);
    last_served = 1;

    // Both channels at once: ch0 first, then ch1 one divide period later.
    valid_edges.delete();
    exp_q.push_back(exp_word(0, 1'b0, 16'h0300));
    exp_q.push_back(exp_word(1, 1'b0, 16'h0100));
    send(2'b11, 16'd300, 16'd100, 16'd100, 16'd100, k);
    drain(6 * LAT);
    check("lat_pair_first", lat_of(0, k), LAT);
    check("lat_pair_second", lat_of(1, k), 2 * LAT);
    last_served = 1;

    // Strobe on the consume edge: no overrun, both pairs served.
    valid_edges.delete();
    exp_q.push_back(exp_word(0, 1'b0, 16'h0300));
    exp_q.push_back(exp_word(0, 1'b0, 16'h0200));
    put(2'b01, 16'd300, 16'd100, 16'd0, 16'd0, k);
    put(2'b01, 16'd50, 16'd25, 16'd0, 16'd0, k2);
    release_inputs();
    drain(6 * LAT);
    check("coincident_no_overrun", o_overrun, 2'b00);
    check("lat_coincident_second", lat_of(1, k), 2 * LAT);
    last_served = 0;

    // Overrun: ch0 strobed twice while the divider is busy with ch1.
    valid_edges.delete();
    exp_q.push_back(exp_word(1, 1'b0, 16'h0380));
    exp_q.push_back(exp_word(0, 1'b0, 16'h0200));
    send(2'b10, 16'd0, 16'd0, 16'd7, 16'd2, k);
    send(2'b01, 16'd300, 16'd100, 16'd0, 16'd0, k2);
    send(2'b01, 16'd50, 16'd25, 16'd0, 16'd0, k2);
    drain(6 * LAT);
    check("overrun_flag", o_overrun, 2'b01);
    repeat (5) @(negedge clk);
    check("overrun_sticky", o_overrun, 2'b01);
    last_served = 0;

    // Reset at edge k+10 of a division aborts it and clears everything.
    put(2'b01, 16'd10, 16'd3, 16'd0, 16'd0, k);
    release_inputs();
    while (edge_cnt < k + 9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("abort");
    rst = 1'b0;
    vc = valid_count;
    repeat (2 * LAT) @(negedge clk);
    check("no_valid_after_abort", valid_count - vc, 0);
    last_served = NCH - 1;
    valid_edges.delete();
    exp_q.push_back(exp_word(1, 1'b0, 16'h0100));
    send(2'b10, 16'd0, 16'd0, 16'd100, 16'd100, k);
    drain(4 * LAT);
    check("lat_after_abort", lat_of(0, k), LAT);
    last_served = 1;

    // Randomized operands and channel masks.
    for (int it = 0; it < 24; it++) begin
      logic [NCH-1:0] m;
      logic [A-1:0]   r[NCH];
      logic [A-1:0]   e[NCH];
      int             first;
      int             c;
      m = NCH'($urandom_range(1, 3));
      for (int ch = 0; ch < NCH; ch++) begin
        case ($urandom_range(0, 4))
          0:       begin r[ch] = A'($urandom); e[ch] = '0; end
          1:       begin r[ch] = A'($urandom); e[ch] = A'($urandom_range(1, 15)); end
          2:       begin r[ch] = A'($urandom_range(0, 255)); e[ch] = A'($urandom); end
          default: begin r[ch] = A'($urandom); e[ch] = A'($urandom); end
        endcase
      end
      first = (last_served + 1) % NCH;
      for (int j = 0; j < NCH; j++) begin
        c = (first + j) % NCH;
        if (m[c]) begin
          exp_q.push_back(model(c, r[c], e[c]));
          last_served = c;
        end
      end
      valid_edges.delete();
      send(m, r[0], e[0], r[1], e[1], k);
      drain(6 * LAT);
      check("rand_lat", lat_of(0, k), LAT);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
